mem_refill_arbiter: RTL and testbench
=====================================

# mem_refill_arbiter

Sequencer and arbiter for the single backing-memory port shared by the instruction cache and the 2-way data cache. It accepts line-refill requests from both caches and word write-through requests from the data cache, grants one at a time with round-robin fairness, and runs each one as a request/ack handshake on a 32-bit memory bus. Refills assemble a 64-bit line, two words, to match the 8-byte cache line. The block sits between the cache miss logic (`miss_stall` sources) and the RAM model.

## Interface
- `WIDTH`, 32, CPU address/data width
- `ADDR_BITS`, 17, byte-address width of backing memory
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_req`  in  1  instruction-cache refill request, level, held until `i_done`
- `i_addr`  in  WIDTH  instruction miss byte address
- `d_req`  in  1  data-cache request (refill or write), level, held until `d_done`
- `d_we`  in  1  1 = write-through word, 0 = line refill
- `d_addr`  in  WIDTH  data byte address
- `d_wdata`  in  32  write data
- `d_wmask`  in  4  byte enables for write
- `i_done`  out  1  one-cycle pulse, instruction refill complete
- `d_done`  out  1  one-cycle pulse, data refill/write complete
- `line_data`  out  64  refilled line {hi word, lo word}, valid in done cycle, held until next refill
- `busy`  out  1  high in any state other than IDLE
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_BITS  word-aligned byte address
- `mem_wdata`  out  32  write data
- `mem_wmask`  out  4  byte enables
- `mem_ack`  in  1  memory accepts request; read data valid same cycle
- `mem_rdata`  in  32  read data

## Operation
- States: IDLE, RD_LO, RD_HI, WR, DONE.
- IDLE: sample `i_req`/`d_req`. If neither is set, stay. If only one is set, grant it. If both are set, grant the port not granted last (`last_gnt`; reset value = data, so instruction wins the first tie). On grant, latch the owner, the address, and for data writes `d_we`/`d_wdata`/`d_wmask`.
- Grant, refill: go to RD_LO. Base = {addr[ADDR_BITS-1:3], 3'b000}. Address bits above ADDR_BITS and bits [2:0] are ignored.
- Grant, data write: go to WR. `mem_addr` = {addr[ADDR_BITS-1:2], 2'b00}.
- RD_LO: `mem_req`=1, `mem_addr`=base. On `mem_ack`, capture `mem_rdata` into line_data[31:0] and go to RD_HI.
- RD_HI: `mem_req`=1, `mem_addr`=base|4, with no carry into bit 3. On `mem_ack`, capture into line_data[63:32] and go to DONE.
- WR: `mem_req`=1, `mem_we`=1, `mem_wdata`/`mem_wmask` from latched values. On `mem_ack`, go to DONE. `line_data` is unchanged by writes.
- DONE: pulse the owner's done output for exactly one cycle, update `last_gnt` to the owner, go to IDLE. Requests are ignored in DONE.
- The requester must have dropped `req` by the edge ending DONE. A request still high in the following IDLE cycle is treated as a new request.
- `mem_req` is low in IDLE and DONE. `mem_we` is high only in WR. `mem_addr`, `mem_wdata` and `mem_wmask` are don't-care while `mem_req`=0; drive them 0.
- Memory must hold `mem_rdata`/`mem_ack` meaning only in states with `mem_req`=1. `mem_ack` in any other state is ignored.
- Changes on `i_addr`/`d_addr` after grant have no effect.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, `last_gnt`=data, `line_data`=0. All outputs are 0 immediately, including `mem_req`, `busy` and both done outputs.
- Reset mid-transaction aborts with no done pulse. The requester re-requests after reset.
- Zero-wait refill: request seen at edge 0 → RD_LO cycle 1, RD_HI cycle 2, done pulse cycle 3. Latency = 3 cycles + total wait states.
- Zero-wait write: WR cycle 1, done cycle 2.
- Each memory wait cycle (`mem_req`=1, `mem_ack`=0) extends the current state by one cycle.
- Back-to-back: after DONE, one IDLE cycle precedes the next grant. Minimum refill-to-refill spacing is therefore 4 cycles.

## Test plan
- Single I refill at i_addr=0x0001_0008, zero-wait memory with words 0xAAAA0001/0xBBBB0002 → `mem_addr` 0x10008 then 0x1000C, `i_done` in cycle 3, `line_data`=0xBBBB0002_AAAA0001.
- Simultaneous `i_req` and `d_req` refill after reset → instruction served first, data served next. With both re-asserted, the order then alternates D, I, D.
- D refill with mem_ack delayed 2 cycles on each word → `d_done` in cycle 7, `mem_req` held stable and `mem_addr` unchanged during the waits.
- D write d_addr=0x0001_0006, d_wdata=0x12345678, d_wmask=4'b0011 → one request with `mem_we`=1, `mem_addr`=0x10004, mask 0011, `d_done` in cycle 2, `line_data` unchanged.
- Assert rst low during RD_HI → `mem_req`, `busy` and `line_data` go 0 asynchronously, no done pulse. After release, a fresh I/D tie grants instruction.
- Requester holds `i_req` high one cycle past `i_done` → second refill of the same line starts; stray `mem_ack` in IDLE causes no state change.

Source files
------------

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter and sequencer for the shared backing-memory port:
// two-word line refills for I$/D$ and single-word D$ write-through.
module mem_refill_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [WIDTH-1:0]     i_addr,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WIDTH-1:0]     d_addr,
  input  logic [31:0]          d_wdata,
  input  logic [3:0]           d_wmask,
  output logic                 i_done,
  output logic                 d_done,
  output logic [63:0]          line_data,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, DONE} state_t;

  state_t               state, state_next;
  logic                 owner_d;
  logic                 last_d;
  logic [ADDR_BITS-3:0] word_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wmask_q;
  logic                 gnt_any;
  logic                 gnt_d;
  logic [ADDR_BITS-3:0] gnt_word;
  logic                 unused_addr;

  // Address bits above the memory and the byte offset never reach the port.
  assign unused_addr = ^{i_addr[WIDTH-1:ADDR_BITS], i_addr[1:0],
                         d_addr[WIDTH-1:ADDR_BITS], d_addr[1:0]};

  always_comb begin
    gnt_any    = i_req | d_req;
    gnt_d      = d_req & (~i_req | ~last_d);
    gnt_word   = gnt_d ? d_addr[ADDR_BITS-1:2] : i_addr[ADDR_BITS-1:2];
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (gnt_any) state_next = (gnt_d && d_we) ? WR : RD_LO;
      RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = {word_q[ADDR_BITS-3:1], 3'b000};
        if (mem_ack) state_next = RD_HI;
      end
      RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = {word_q[ADDR_BITS-3:1], 3'b100};
        if (mem_ack) state_next = DONE;
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {word_q, 2'b00};
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
        if (mem_ack) state_next = DONE;
      end
      DONE: begin
        i_done     = ~owner_d;
        d_done     = owner_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      word_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      line_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && gnt_any) begin
        owner_d <= gnt_d;
        word_q  <= gnt_word;
        if (gnt_d && d_we) begin
          wdata_q <= d_wdata;
          wmask_q <= d_wmask;
        end
      end
      if (state == RD_LO && mem_ack) line_data[31:0]  <= mem_rdata;
      if (state == RD_HI && mem_ack) line_data[63:32] <= mem_rdata;
      if (state == DONE) last_d <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter with a small wait-state memory responder.
module tb_mem_refill_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        i_done;
  logic        d_done;
  logic [63:0] line_data;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned wait_cfg;
  int unsigned wcnt;
  logic        stray;
  int          checks;
  int          errors;

  mem_refill_arbiter #(.WIDTH(32), .ADDR_BITS(17)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .i_done(i_done), .d_done(d_done), .line_data(line_data), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [16:0] a);
    case (a)
      17'h10008: mem_word = 32'hAAAA0001;
      17'h1000C: mem_word = 32'hBBBB0002;
      default:   mem_word = 32'hC0DE0000 | {15'b0, a};
    endcase
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign mem_ack   = stray | (mem_req & (wcnt == wait_cfg));

  always_ff @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input bit exp_d, input logic [63:0] exp_line);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_done || d_done) && n < 20);
    check({tag, "_who"}, {62'b0, d_done, i_done}, exp_d ? 64'd2 : 64'd1);
    check({tag, "_line"}, line_data, exp_line);
  endtask

  initial begin
    wcnt = 0; checks = 0; errors = 0; wait_cfg = 0; stray = 1'b0;
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {i_done, d_done}, 0);
    check("rst_line", line_data, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // single instruction refill, zero wait
    i_addr = 32'h0001_0008; i_req = 1'b1;
    @(negedge clk);
    check("t1_c1_req", mem_req, 1);
    check("t1_c1_addr", mem_addr, 64'h10008);
    check("t1_c1_we", mem_we, 0);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_idone", i_done, 0);
    @(negedge clk);
    check("t1_c2_addr", mem_addr, 64'h1000C);
    @(negedge clk);
    check("t1_c3_idone", i_done, 1);
    check("t1_c3_ddone", d_done, 0);
    check("t1_c3_line", line_data, 64'hBBBB0002_AAAA0001);
    check("t1_c3_req", mem_req, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("t1_idle_idone", i_done, 0);
    check("t1_idle_busy", busy, 0);

    // tie after reset: I first, then alternation D, I, D
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
    @(negedge clk);
    check("tie_first_addr", mem_addr, 64'h10008);
    @(negedge clk); @(negedge clk);
    check("tie_first_who", {d_done, i_done}, 2'b01);
    i_req = 1'b0;
    @(negedge clk);
    i_req = 1'b1;
    wait_done("alt_d1", 1'b1, 64'hC0DE0104_C0DE0100);
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1;
    wait_done("alt_i", 1'b0, 64'hBBBB0002_AAAA0001);
    i_req = 1'b0;
    @(negedge clk);
    i_req = 1'b1;
    wait_done("alt_d2", 1'b1, 64'hC0DE0104_C0DE0100);
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);

    // data refill with two wait states per word; address moves after grant
    wait_cfg = 2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("wait_lo_req_c%0d", c), mem_req, 1);
      check($sformatf("wait_lo_addr_c%0d", c), mem_addr, 64'h200);
      d_addr = 32'h0000_0FF0;
    end
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("wait_hi_req_c%0d", c), mem_req, 1);
      check($sformatf("wait_hi_addr_c%0d", c), mem_addr, 64'h204);
    end
    @(negedge clk);
    check("wait_c7_ddone", d_done, 1);
    check("wait_c7_line", line_data, 64'hC0DE0204_C0DE0200);
    d_req = 1'b0;
    @(negedge clk);

    // data write-through
    wait_cfg = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0001_0006;
    d_wdata = 32'h12345678; d_wmask = 4'b0011;
    @(negedge clk);
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 64'h10004);
    check("wr_wdata", mem_wdata, 64'h12345678);
    check("wr_wmask", mem_wmask, 64'h3);
    @(negedge clk);
    check("wr_ddone", d_done, 1);
    check("wr_we_off", mem_we, 0);
    check("wr_line_kept", line_data, 64'hC0DE0204_C0DE0200);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    // reset asserted during RD_HI
    i_req = 1'b1; i_addr = 32'h0001_0008;
    @(negedge clk); @(negedge clk);
    check("rsthi_addr", mem_addr, 64'h1000C);
    #2 rst = 1'b0;
    #1;
    check("rsthi_req", mem_req, 0);
    check("rsthi_busy", busy, 0);
    check("rsthi_line", line_data, 0);
    check("rsthi_idone", i_done, 0);
    d_req = 1'b1; d_addr = 32'h0000_0100;
    @(negedge clk);
    check("rsthi_held_done", {i_done, d_done}, 0);
    check("rsthi_held_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_grant_i", mem_addr, 64'h10008);
    wait_done("post_rst_i", 1'b0, 64'hBBBB0002_AAAA0001);
    i_req = 1'b0;
    wait_done("post_rst_d", 1'b1, 64'hC0DE0104_C0DE0100);
    d_req = 1'b0;
    @(negedge clk);

    // i_req held one cycle past i_done; high address bits and offset ignored
    i_req = 1'b1; i_addr = 32'h1234_000D;
    @(negedge clk);
    check("hold_c1_addr", mem_addr, 64'h8);
    @(negedge clk);
    check("hold_c2_addr", mem_addr, 64'hC);
    @(negedge clk);
    check("hold_c3_idone", i_done, 1);
    check("hold_c3_line", line_data, 64'hC0DE000C_C0DE0008);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_idone", i_done, 0);
    @(negedge clk);
    check("hold_regrant_req", mem_req, 1);
    check("hold_regrant_addr", mem_addr, 64'h8);
    i_req = 1'b0;
    wait_done("hold_second", 1'b0, 64'hC0DE000C_C0DE0008);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_req", mem_req, 0);
    check("stray_line", line_data, 64'hC0DE000C_C0DE0008);
    @(negedge clk);
    check("stray_done", {i_done, d_done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
